// File: rtl/root_nth_iter.sv
// Bit-serial n-th root: out_data = largest r (Q(DIN_W).(FRAC_W)) with r^n <= x, with a truncating multiply per POW cycle.
// Latency OUT_W*(n+2)+1 cycles for n>=2, 1 cycle for n<2; result held until out_ready. Build macro: ROOT_EARLY_EXIT_EN.
// Backpressure: in_ready only in IDLE, requests while busy are dropped; DONE holds outputs until out_ready.
module root_nth_iter #(
    parameter int DIN_W  = 10,
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 5,
    parameter int OUT_W  = DIN_W + FRAC_W,
    parameter int ACC_W  = OUT_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DIN_W-1:0] in_data_1,
    input  logic [EXP_W-1:0] in_data_2,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_exact,
    output logic             out_err
);
    localparam int BW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PR_W = ACC_W + OUT_W;

    typedef enum logic [2:0] {S_IDLE, S_TRIAL, S_POW, S_CMP, S_DONE} state_t;

    state_t           state, state_nx;
    logic [DIN_W-1:0] x_q;
    logic [EXP_W-1:0] n_q;
    logic [EXP_W-1:0] k_q;
    logic [OUT_W-1:0] r_q;
    logic [OUT_W-1:0] t_q;
    logic [BW-1:0]    b_q;
    logic [ACC_W-1:0] p_q;
    logic             exact_q;
    logic             err_q;

    logic             accept;
    logic [ACC_W-1:0] x_cmp;
    logic [PR_W-1:0]  prod;
    logic [PR_W-1:0]  prod_sh;
    logic [ACC_W-1:0] p_step;
    logic             trial_le;
    logic             trial_eq;
    logic             last_pow;
    logic             early_stop;

    assign accept   = (state == S_IDLE) && in_valid;
    assign x_cmp    = ACC_W'(OUT_W'(x_q) << FRAC_W);
    assign prod     = PR_W'(p_q) * PR_W'(t_q);
    assign prod_sh  = prod >> FRAC_W;
    // Saturate so a huge trial can never wrap around and look small.
    assign p_step   = (|prod_sh[PR_W-1:ACC_W]) ? {ACC_W{1'b1}} : prod_sh[ACC_W-1:0];
    assign trial_le = (p_q <= x_cmp);
    assign trial_eq = (p_q == x_cmp);
    assign last_pow = (k_q == n_q - EXP_W'(1));

`ifdef ROOT_EARLY_EXIT_EN
    assign early_stop = trial_eq;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = (in_data_2 < EXP_W'(2)) ? S_DONE : S_TRIAL;
            S_TRIAL: state_nx = S_POW;
            S_POW:   if (last_pow) state_nx = S_CMP;
            S_CMP:   state_nx = ((b_q == '0) || early_stop) ? S_DONE : S_TRIAL;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        out_data  = out_valid ? r_q : '0;
        out_exact = out_valid & exact_q;
        out_err   = out_valid & err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    x_q     <= in_data_1;
                    n_q     <= in_data_2;
                    b_q     <= BW'(OUT_W - 1);
                    exact_q <= (in_data_2 == EXP_W'(1));
                    err_q   <= (in_data_2 == '0);
                    r_q     <= (in_data_2 == EXP_W'(1)) ? (OUT_W'(in_data_1) << FRAC_W) : '0;
                end
                S_TRIAL: begin
                    t_q <= r_q | (OUT_W'(1) << b_q);
                    p_q <= ACC_W'(1) << FRAC_W;
                    k_q <= '0;
                end
                S_POW: begin
                    p_q <= p_step;
                    k_q <= k_q + EXP_W'(1);
                end
                S_CMP: begin
                    if (trial_le) r_q <= t_q;
                    if (trial_eq) exact_q <= 1'b1;
                    if (b_q != '0) b_q <= b_q - BW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_root_nth_iter.sv
// Scoreboard bench for root_nth_iter: expectations queued at request time, compared when out_valid appears.
module tb_root_nth_iter;
    localparam int DIN_W  = 10;
    localparam int EXP_W  = 3;
    localparam int FRAC_W = 5;
    localparam int OUT_W  = DIN_W + FRAC_W;
    localparam int TMO    = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [DIN_W-1:0] in_data_1 = '0;
    logic [EXP_W-1:0] in_data_2 = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_exact;
    logic             out_err;

    typedef struct {
        int data;
        bit exact;
        bit err;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    root_nth_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exact (out_exact),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Behavioural reference of the bit-serial search, used for random traffic.
    function automatic exp_t ref_root(input int x, input int n);
        exp_t e;
        longint r, t, p, xs, sh;
        e.err = (n == 0); e.exact = 0; e.data = 0; e.lat = 1;
        if (n == 1) begin e.data = x << FRAC_W; e.exact = 1; end
        if (n >= 2) begin
            r = 0; xs = longint'(x) << FRAC_W;
            for (int b = OUT_W - 1; b >= 0; b--) begin
                t = r | (longint'(1) << b);
                p = 1 << FRAC_W;
                for (int k = 0; k < n; k++) begin
                    sh = (p * t) >> FRAC_W;
                    p  = (sh > 65535) ? 65535 : sh;
                end
                e.lat += n + 2;
                if (p <= xs) r = t;
                if (p == xs) begin
                    e.exact = 1;
`ifdef ROOT_EARLY_EXIT_EN
                    break;
`endif
                end
            end
            e.data = int'(r);
        end
        return e;
    endfunction

    task automatic send(input int x, input int n, input exp_t e);
        int w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid  = 1'b1;
        in_data_1 = DIN_W'(x);
        in_data_2 = EXP_W'(n);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
    endtask

    // Called at the negedge of cycle 1 after acceptance; leaves out_valid held.
    task automatic collect(input string name);
        exp_t e;
        int lat = 1;
        while (out_valid !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: output with empty scoreboard", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
            return;
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL %s_lat: got %0d required %0d", name, lat, e.lat); end
        checks++;
        if (out_data !== OUT_W'(e.data)) begin errors++; $display("FAIL %s_data: got %0d required %0d", name, out_data, e.data); end
        checks++;
        if (out_exact !== e.exact) begin errors++; $display("FAIL %s_exact: got %b required %b", name, out_exact, e.exact); end
        checks++;
        if (out_err !== e.err) begin errors++; $display("FAIL %s_err: got %b required %b", name, out_err, e.err); end
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_exact !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_clear: valid=%b data=%0d exact=%b err=%b in_ready=%b required 0/0/0/0/1",
                     name, out_valid, out_data, out_exact, out_err, in_ready);
        end
    endtask

    function automatic exp_t mk(input int d, input bit ex, input bit er, input int l);
        exp_t e;
        e.data = d; e.exact = ex; e.err = er; e.lat = l;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_exact !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b valid=%b data=%0d exact=%b err=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_data, out_exact, out_err);
        end
    endtask

    task automatic test_exact_sqrt();
`ifdef ROOT_EARLY_EXIT_EN
        send(4, 2, mk(64, 1, 0, 37));
`else
        send(4, 2, mk(64, 1, 0, 61));
`endif
        collect("exact_sqrt");
        release_out("exact_sqrt");
    endtask

    task automatic test_inexact_sqrt();
        send(2, 2, mk(45, 0, 0, 61));
        collect("inexact_sqrt");
        release_out("inexact_sqrt");
    endtask

    task automatic test_large_exp();
        send(1023, 7, mk(86, 0, 0, 136));
        collect("large_exp");
        release_out("large_exp");
    endtask

    task automatic test_degenerate();
        send(9, 0, mk(0, 0, 1, 1));
        collect("n0");
        release_out("n0");
        send(9, 1, mk(288, 1, 0, 1));
        collect("n1");
        release_out("n1");
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] d0;
        logic             e0;
        send(2, 2, mk(45, 0, 0, 61));
        collect("bp");
        d0 = out_data;
        e0 = out_exact;
        in_valid  = 1'b1;
        in_data_1 = DIN_W'(9);
        in_data_2 = EXP_W'(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== d0 || out_exact !== e0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d exact=%b in_ready=%b required 1/%0d/%b/0",
                         i, out_valid, out_data, out_exact, in_ready, d0, e0);
            end
        end
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_dropped: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        send(2, 2, mk(45, 0, 0, 61));
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_exact !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b valid=%b data=%0d exact=%b err=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_data, out_exact, out_err);
        end
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_partial: out_valid=%b required 0", out_valid);
        end
        send(2, 2, mk(45, 0, 0, 61));
        collect("reset_mid_fresh");
        release_out("reset_mid_fresh");
    endtask

    task automatic test_back_to_back();
        int x, n;
        for (int i = 0; i < 5; i++) begin
            x = $urandom_range(1, 1023);
            n = $urandom_range(2, 4);
            send(x, n, ref_root(x, n));
            collect("b2b");
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_exact_sqrt();
        test_inexact_sqrt();
        test_large_exp();
        test_degenerate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
